pixie_paged_frame_buffer: RTL and testbench

PIXIE_PAGED_FRAME_BUFFER -- requirements
Module: pixie_paged_frame_buffer

---
 rtl/pixie_paged_frame_buffer.sv | 135 +++++++++++++
 tb/tb_pixie_paged_frame_buffer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pixie_paged_frame_buffer.sv
// Paged frame buffer: CPU-side write page, display-side read page, vsync-timed
// page swap and a hardware clear engine that fills the write page.
module pixie_paged_frame_buffer #(
    parameter int unsigned       DATA_W     = 8,
    parameter int unsigned       ADDR_W     = 10,
    parameter int unsigned       DOUBLE_BUF = 1,
    parameter logic [DATA_W-1:0] CLEAR_VAL  = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              swap_req,
    input  logic              vsync,
    input  logic              clear_req,
    output logic              busy,
    output logic              disp_page,
    output logic              swap_pending,
    output logic              wr_drop
);

    localparam int unsigned PA_W  = ADDR_W + ((DOUBLE_BUF != 0) ? 1 : 0);
    localparam int unsigned DEPTH = 1 << PA_W;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cnt, cnt_nxt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [PA_W-1:0]   rd_pa, wr_pa, clr_pa, mem_wa;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wd;
    logic              vsync_q, vsync_rise, swap_go;

    generate
        if (DOUBLE_BUF != 0) begin : g_paged
            assign rd_pa  = {disp_page, rd_addr};
            assign wr_pa  = {~disp_page, wr_addr};
            assign clr_pa = {~disp_page, cnt};
        end else begin : g_single
            assign rd_pa  = rd_addr;
            assign wr_pa  = wr_addr;
            assign clr_pa = cnt;
        end
    endgenerate

    assign busy       = (state == CLEAR);
    assign vsync_rise = vsync & ~vsync_q;
    assign swap_go    = vsync_rise & (swap_pending | swap_req) & ~busy;

    // The clear engine owns the write port while busy; CPU writes are dropped.
    always_comb begin
        mem_we = reset_n & (busy | wr_en);
        mem_wa = busy ? clr_pa : wr_pa;
        mem_wd = busy ? CLEAR_VAL : wr_data;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (clear_req) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end
            end
            CLEAR: begin
                if (&cnt) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + ADDR_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    // Write-first bypass; only reachable when both sides share one page.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= (mem_we && (mem_wa == rd_pa)) ? mem_wd : mem[rd_pa];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            vsync_q      <= 1'b0;
            disp_page    <= 1'b0;
            swap_pending <= 1'b0;
            wr_drop      <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            vsync_q <= vsync;
            wr_drop <= wr_en & busy;
            if (DOUBLE_BUF != 0) begin
                if (swap_go) begin
                    disp_page    <= ~disp_page;
                    swap_pending <= 1'b0;
                end else if (swap_req) begin
                    swap_pending <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pixie_paged_frame_buffer.sv
// Bench for pixie_paged_frame_buffer: a double-buffered instance and a
// single-page instance, with read responses checked through scoreboards.
module tb_pixie_paged_frame_buffer;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic       a_wr_en, a_rd_en, a_swap_req, a_vsync, a_clear_req;
    logic [9:0] a_wr_addr, a_rd_addr;
    logic [7:0] a_wr_data, a_rd_data;
    logic       a_rd_valid, a_busy, a_disp_page, a_swap_pending, a_wr_drop;

    logic       b_wr_en, b_rd_en, b_swap_req, b_vsync, b_clear_req;
    logic [9:0] b_wr_addr, b_rd_addr;
    logic [7:0] b_wr_data, b_rd_data;
    logic       b_rd_valid, b_busy, b_disp_page, b_swap_pending, b_wr_drop;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] q_a[$];
    logic [7:0] q_b[$];
    logic [7:0] exp_a, exp_b;

    pixie_paged_frame_buffer #(
        .DATA_W(8), .ADDR_W(10), .DOUBLE_BUF(1), .CLEAR_VAL(8'h00)
    ) dut_a (
        .clk(clk), .reset_n(reset_n),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_valid(a_rd_valid),
        .swap_req(a_swap_req), .vsync(a_vsync), .clear_req(a_clear_req),
        .busy(a_busy), .disp_page(a_disp_page), .swap_pending(a_swap_pending),
        .wr_drop(a_wr_drop)
    );

    pixie_paged_frame_buffer #(
        .DATA_W(8), .ADDR_W(10), .DOUBLE_BUF(0), .CLEAR_VAL(8'h00)
    ) dut_b (
        .clk(clk), .reset_n(reset_n),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
        .swap_req(b_swap_req), .vsync(b_vsync), .clear_req(b_clear_req),
        .busy(b_busy), .disp_page(b_disp_page), .swap_pending(b_swap_pending),
        .wr_drop(b_wr_drop)
    );

    always @(negedge clk) begin
        if (a_rd_valid) begin
            n_checks++;
            if (q_a.size() == 0) begin
                n_fail++;
                $display("FAIL a_rd_unexpected: got %0h, required no response", a_rd_data);
            end else begin
                exp_a = q_a.pop_front();
                if (a_rd_data !== exp_a) begin
                    n_fail++;
                    $display("FAIL a_rd_data: got %0h, required %0h", a_rd_data, exp_a);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (b_rd_valid) begin
            n_checks++;
            if (q_b.size() == 0) begin
                n_fail++;
                $display("FAIL b_rd_unexpected: got %0h, required no response", b_rd_data);
            end else begin
                exp_b = q_b.pop_front();
                if (b_rd_data !== exp_b) begin
                    n_fail++;
                    $display("FAIL b_rd_data: got %0h, required %0h", b_rd_data, exp_b);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_write(input logic [9:0] ad, input logic [7:0] d);
        a_wr_en = 1'b1; a_wr_addr = ad; a_wr_data = d;
        tick();
        a_wr_en = 1'b0;
    endtask

    task automatic a_read(input logic [9:0] ad, input logic [7:0] e);
        a_rd_en = 1'b1; a_rd_addr = ad;
        q_a.push_back(e);
        tick();
        a_rd_en = 1'b0;
    endtask

    function automatic logic [7:0] pat(input int i);
        logic [31:0] v;
        v = i;
        return {1'b1, v[6:0]};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        reset_n = 1'b0;
        {a_wr_en, a_rd_en, a_swap_req, a_vsync, a_clear_req} = '0;
        {b_wr_en, b_rd_en, b_swap_req, b_vsync, b_clear_req} = '0;
        a_wr_addr = '0; a_rd_addr = '0; a_wr_data = '0;
        b_wr_addr = '0; b_rd_addr = '0; b_wr_data = '0;
        #1;
        chk("rst_rd_data", a_rd_data, 0);
        chk("rst_rd_valid", a_rd_valid, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_disp_page", a_disp_page, 0);
        chk("rst_swap_pending", a_swap_pending, 0);
        chk("rst_wr_drop", a_wr_drop, 0);
        tick();
        reset_n = 1'b1;

        // Single page: read after write, then same-cycle write-first.
        b_wr_en = 1'b1; b_wr_addr = 10'h123; b_wr_data = 8'hA5;
        tick();
        b_wr_en = 1'b0;
        b_rd_en = 1'b1; b_rd_addr = 10'h123; q_b.push_back(8'hA5);
        tick();
        b_wr_en = 1'b1; b_wr_addr = 10'h010; b_wr_data = 8'h3C;
        b_rd_en = 1'b1; b_rd_addr = 10'h010; q_b.push_back(8'h3C);
        tick();
        b_wr_en = 1'b0; b_rd_en = 1'b0;
        tick();
        chk("b_rd_data_hold", b_rd_data, 8'h3C);
        b_swap_req = 1'b1; b_vsync = 1'b1;
        tick();
        b_swap_req = 1'b0; b_vsync = 1'b0;
        chk("b_disp_page_fixed", b_disp_page, 0);
        chk("b_swap_pending_fixed", b_swap_pending, 0);

        // Double buffer swap.
        a_write(10'h000, 8'h55);
        a_swap_req = 1'b1; tick(); a_swap_req = 1'b0;
        chk("swap_pending_set", a_swap_pending, 1);
        chk("page_before_vsync", a_disp_page, 0);
        a_swap_req = 1'b1; tick(); a_swap_req = 1'b0;
        chk("swap_pending_repeat", a_swap_pending, 1);
        chk("page_repeat_req", a_disp_page, 0);
        a_vsync = 1'b1; tick();
        chk("page_swapped", a_disp_page, 1);
        chk("swap_pending_clear", a_swap_pending, 0);
        a_read(10'h000, 8'h55);
        a_vsync = 1'b0; tick();
        a_vsync = 1'b1; tick();
        chk("page_no_pending_vsync", a_disp_page, 1);
        a_vsync = 1'b0; tick();

        // Clear of page 0 with a dropped write, ignored re-request and blocked swap.
        for (int i = 0; i < 1024; i++) a_write(i[9:0], pat(i));
        a_clear_req = 1'b1; tick(); a_clear_req = 1'b0;
        chk("busy_rise", a_busy, 1);
        cnt = 0;
        while (a_busy && cnt < 2000) begin
            cnt++;
            if (cnt == 6) chk("wr_drop_pulse", a_wr_drop, 1);
            if (cnt == 7) chk("wr_drop_once", a_wr_drop, 0);
            if (cnt == 51) begin
                chk("swap_blocked_page", a_disp_page, 1);
                chk("swap_blocked_pending", a_swap_pending, 1);
            end
            if (cnt == 5) begin a_wr_en = 1'b1; a_wr_addr = 10'd3; a_wr_data = 8'h99; end
            if (cnt == 10) a_clear_req = 1'b1;
            if (cnt == 20) begin a_rd_en = 1'b1; a_rd_addr = 10'h000; q_a.push_back(8'h55); end
            if (cnt == 50) begin a_swap_req = 1'b1; a_vsync = 1'b1; end
            if (cnt == 60) a_vsync = 1'b0;
            tick();
            a_wr_en = 1'b0; a_clear_req = 1'b0; a_rd_en = 1'b0; a_swap_req = 1'b0;
        end
        chk("busy_cycles", cnt, 1024);
        chk("pending_after_clear", a_swap_pending, 1);
        chk("page_after_clear", a_disp_page, 1);
        a_vsync = 1'b1; tick(); a_vsync = 1'b0;
        chk("page_deferred_swap", a_disp_page, 0);
        chk("pending_deferred_clear", a_swap_pending, 0);
        for (int i = 0; i < 1024; i++) begin
            a_rd_en = 1'b1; a_rd_addr = i[9:0]; q_a.push_back(8'h00);
            tick();
        end
        a_rd_en = 1'b0;

        // Reset in the middle of clearing page 1.
        for (int i = 0; i < 1024; i++) a_write(i[9:0], pat(i));
        a_clear_req = 1'b1; tick(); a_clear_req = 1'b0;
        repeat (100) tick();
        #1 reset_n = 1'b0;
        #1;
        chk("abort_busy", a_busy, 0);
        chk("abort_disp_page", a_disp_page, 0);
        chk("abort_rd_valid", a_rd_valid, 0);
        tick();
        reset_n = 1'b1;
        a_swap_req = 1'b1; a_vsync = 1'b1; tick();
        a_swap_req = 1'b0; a_vsync = 1'b0;
        chk("post_reset_swap", a_disp_page, 1);
        for (int i = 0; i < 1024; i++) begin
            a_rd_en = 1'b1; a_rd_addr = i[9:0];
            q_a.push_back(i < 100 ? 8'h00 : pat(i));
            tick();
        end
        a_rd_en = 1'b0;

        repeat (3) tick();
        chk("q_a_drained", q_a.size(), 0);
        chk("q_b_drained", q_b.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
